uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial receiver that sits directly upstream of the UART-loaded program RAM.
- Recovers 8N1 bytes from the raw rx pin and hands each byte to the RAM loader over a valid/ready handshake.
- The loader assembles bytes into 16-bit words, low byte first. That logic is not part of this block.
- Adds input synchronisation, majority-vote sampling, false-start rejection, framing-error and overrun detection.

Parameters:
- DELAY, 234, clocks per bit period (27 MHz / 115200). Legal range ≥ 8.
- HALF, DELAY/2, clocks from start-edge detect to the start-bit centre. Derived; not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rx  in  1  raw asynchronous serial input, idle high
- data_ready  in  1  consumer accepts data_out this cycle
- clr_err  in  1  one-cycle pulse that clears the overrun flag
- data_out  out  8  received byte, LSB received first
- data_valid  out  1  data_out holds an unconsumed byte
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: a good byte was dropped because the holding register was full
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at posedge clk):
  - synchroniser and vote history load 1s; state=IDLE; counters=0.
  - data_out=0x00, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no output is produced for it.
- Input path:
  - rx passes through a 2-FF synchroniser, giving rx_s (2 cycles of latency).
  - A 3-bit shift history of rx_s is kept. vote = majority of the history at the sampling cycle.
- State machine, with a bit counter cnt (0..DELAY-1) and a bit index (0..7):
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: when cnt==HALF-1, check vote.
    - vote==1: false start. Return to IDLE with no flags raised.
    - vote==0: go to DATA with cnt=0, index=0.
  - DATA: when cnt==DELAY-1, shift vote into the shift register MSB (right shift), so bit 0 lands at the LSB.
    - After index 7, go to STOP with cnt=0.
  - STOP: when cnt==DELAY-1, check vote.
    - vote==1: good byte. Go to IDLE. This sample is at mid stop bit, so a back-to-back start edge is caught.
    - vote==0: pulse frame_err for one cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line yields exactly one frame_err.
- Holding register and handshake:
  - A transfer occurs on any cycle with data_valid && data_ready.
  - data_valid falls the cycle after a transfer unless a new byte loads in that same cycle.
  - Good byte with data_valid==0, or with a transfer in the same cycle: data_out loads the shift register and data_valid=1 on the next cycle.
  - Good byte with data_valid==1 and no transfer: the byte is dropped, data_out is unchanged, overrun is set.
  - overrun clears only on clr_err or reset. If clr_err and a new overrun coincide, overrun stays 1 (set wins).
- Latency:
  - data_valid rises 2 + HALF + 9·DELAY + 1 cycles after the rx falling edge (±1 for synchroniser phase).
  - For DELAY=234 this is 2226 ±1 cycles.
- frame_err and data_valid never both assert for the same frame.

Test Plan:
- Idle rx=1, reset released after 10 cycles → all outputs 0, busy=0, no activity for 5000 cycles.
- Send 0x0B with data_ready=1 (DELAY=234) → data_valid high for one cycle, 2226 ±1 cycles after the start edge; data_out=0x0B; frame_err=0, overrun=0.
- Send 0x0B,0x13,0x00,0x0E back-to-back with data_ready=1 → four single-cycle valids carrying exactly those bytes in order, with no frame_err.
- Send 0x13 then 0x0E with data_ready=0 → data_out stays 0x13, data_valid=1, overrun=1. Then pulse clr_err → overrun=0, data_out still 0x13. Raise data_ready → data_valid drops.
- rx low for 50 cycles then high → no data_valid, no frame_err, busy returns to 0 within HALF+3 cycles. Separately, a 1-cycle low glitch at a mid-data-bit sample point → byte still decoded correctly by the vote.
- Frame 0x55 with stop bit forced 0 and rx held low for 3·DELAY → exactly one frame_err pulse, no data_valid, busy until rx returns high. Then a normal 0xA5 → received correctly.
- reset=0 for one cycle during data bit 4 of a frame → outputs zero next cycle, the partial frame produces nothing, and the following byte 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver feeding the program-RAM loader over valid/ready.
// Synchronised, majority-voted sampling with false-start, framing and overrun detection.
module uart_rx_byte #(
  parameter int unsigned DELAY = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ready,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF = DELAY / 2;
  localparam int unsigned CW   = $clog2(DELAY);
  localparam logic [CW-1:0] HALF_END  = CW'(HALF - 1);
  localparam logic [CW-1:0] DELAY_END = CW'(DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    r_sync;
  logic [2:0]    r_hist;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_ovr;
  logic          r_busy;

  logic          w_rx_s;
  logic          w_vote;
  state_t        w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_idx_n;
  logic [7:0]    w_shift_n;
  logic [7:0]    w_data_n;
  logic          w_valid_n;
  logic          w_ferr_n;
  logic          w_ovr_n;
  logic          w_busy_n;
  logic          w_good;
  logic          w_xfer;

  assign w_rx_s = r_sync[1];
  assign w_vote = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_xfer = r_valid & data_ready;

  // Bit-timing FSM plus holding-register / handshake next-state logic.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_good    = 1'b0;
    w_ferr_n  = 1'b0;
    w_data_n  = r_data;
    w_valid_n = r_valid & ~w_xfer;
    w_ovr_n   = r_ovr & ~clr_err;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (!w_rx_s) w_state_n = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_END) begin
          w_cnt_n = '0;
          w_idx_n = '0;
          w_state_n = w_vote ? S_IDLE : S_DATA;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == DELAY_END) begin
          w_cnt_n   = '0;
          w_shift_n = {w_vote, r_shift[7:1]};
          w_idx_n   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_n = S_STOP;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == DELAY_END) begin
          w_cnt_n = '0;
          if (w_vote) begin
            w_good    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_n  = 1'b1;
            w_state_n = S_BREAK;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_BREAK: begin
        w_cnt_n = '0;
        if (w_rx_s) w_state_n = S_IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase

    // A new byte may replace one being consumed this cycle; otherwise it is dropped.
    if (w_good) begin
      if (!r_valid || w_xfer) begin
        w_data_n  = r_shift;
        w_valid_n = 1'b1;
      end else begin
        w_ovr_n = 1'b1;
      end
    end

    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= 2'b11;
      r_hist  <= 3'b111;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_hist  <= {r_hist[1:0], w_rx_s};
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
      r_ovr   <= w_ovr_n;
      r_busy  <= w_busy_n;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: serial frames are generated from bit-level rules and the
// received bytes, flags and timing are compared against expectations built here.
module tb_uart_rx_byte;

  localparam int unsigned DELAY = 234;
  localparam int unsigned HALF  = DELAY / 2;
  localparam int          LAT   = 2 + int'(HALF) + 9 * int'(DELAY) + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         cyc = 0;
  int         rise_cyc = -1;
  int         vcyc = 0;
  int         fe_cnt = 0;
  int         act_cnt = 0;
  logic       prev_v = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_byte #(.DELAY(DELAY)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_ready (data_ready),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the consumer side halfway through each cycle.
  always @(negedge clk) begin
    if (data_valid === 1'b1 && data_ready === 1'b1) got_q.push_back(data_out);
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (data_valid === 1'b1) begin
      vcyc = vcyc + 1;
      if (prev_v !== 1'b1) rise_cyc = cyc;
    end
    prev_v = data_valid;
    if (busy === 1'b1 || data_valid === 1'b1 || frame_err === 1'b1 || overrun === 1'b1)
      act_cnt = act_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; glitch_bit >= 0 puts a one-cycle low pulse near that bit's centre.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    rx = 1'b0;
    tick(DELAY);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == glitch_bit) begin
        tick(HALF - 2);
        rx = 1'b0;
        tick(1);
        rx = b[i];
        tick(DELAY - HALF + 1);
      end else begin
        tick(DELAY);
      end
    end
    rx = stop_bit;
    tick(DELAY);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, -1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(1);
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    act_cnt = 0;
    tick(5000);
    checks++; if (act_cnt !== 0) begin failures++; $display("FAIL idle_activity got=%0d exp=0", act_cnt); end
  endtask

  task automatic test_single;
    logic [7:0] bytes[2];
    int t0;
    bytes[0] = 8'h0B;
    bytes[1] = 8'($urandom);
    data_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      got_q.delete();
      vcyc = 0;
      fe_cnt = 0;
      rise_cyc = -1;
      t0 = cyc;
      send_byte(bytes[k]);
      tick(DELAY);
      checks++; if (got_q.size() != 1 || got_q[0] !== bytes[k]) begin
        failures++; $display("FAIL single_byte got_n=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, bytes[k]);
      end
      checks++; if (rise_cyc - t0 < LAT - 1 || rise_cyc - t0 > LAT + 1) begin
        failures++; $display("FAIL single_latency got=%0d exp=%0d+-1", rise_cyc - t0, LAT);
      end
      checks++; if (vcyc != 1) begin failures++; $display("FAIL single_valid_width got=%0d exp=1", vcyc); end
      checks++; if (fe_cnt != 0 || overrun !== 1'b0) begin
        failures++; $display("FAIL single_flags fe=%0d ovr=%b exp fe=0 ovr=0", fe_cnt, overrun);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    exp_q = '{8'h0B, 8'h13, 8'h00, 8'h0E};
    exp_q.push_back(8'($urandom));
    exp_q.push_back(8'($urandom));
    data_ready = 1'b1;
    got_q.delete();
    vcyc = 0;
    fe_cnt = 0;
    foreach (exp_q[i]) send_byte(exp_q[i]);
    tick(DELAY);
    checks++; if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (vcyc != exp_q.size()) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=%0d", vcyc, exp_q.size()); end
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_overrun;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] hold;
    logic       hold_v;
    logic       ovr;
    logic [7:0] seq[2];
    seq[0] = 8'h13;
    seq[1] = 8'h0E;
    hold = 8'h00; hold_v = 1'b0; ovr = 1'b0;
    data_ready = 1'b0;
    got_q.delete();
    foreach (seq[i]) begin
      send_byte(seq[i]);
      if (!hold_v) begin hold = seq[i]; hold_v = 1'b1; end
      else ovr = 1'b1;
    end
    tick(3);
    checks++; if (data_out !== hold) begin failures++; $display("FAIL ovr_data got=%h exp=%h", data_out, hold); end
    checks++; if (data_valid !== hold_v) begin failures++; $display("FAIL ovr_valid got=%b exp=%b", data_valid, hold_v); end
    checks++; if (overrun !== ovr) begin failures++; $display("FAIL ovr_flag got=%b exp=%b", overrun, ovr); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    checks++; if (data_out !== hold) begin failures++; $display("FAIL ovr_clear_data got=%h exp=%h", data_out, hold); end
    data_ready = 1'b1;
    tick(1);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid got=%b exp=0", data_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== hold) begin
      failures++; $display("FAIL ovr_drain_byte got_n=%0d exp=%h", got_q.size(), hold);
    end
    // clr_err landing on the very cycle a new overrun is detected: set must win.
    data_ready = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    send_byte(a);
    fork
      send_byte(b);
      begin
        tick(LAT - 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
      end
    join
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
    checks++; if (data_out !== a) begin failures++; $display("FAIL ovr_keep_first got=%h exp=%h", data_out, a); end
    clr_err = 1'b1;
    data_ready = 1'b1;
    tick(2);
    clr_err = 1'b0;
  endtask

  task automatic test_false_start;
    int n;
    logic [7:0] b;
    int j;
    data_ready = 1'b1;
    got_q.delete();
    vcyc = 0;
    fe_cnt = 0;
    rx = 1'b0;
    tick(50);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL false_start_busy got=%b exp=1", busy); end
    rx = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < int'(HALF) + 3) begin
      tick(1);
      n++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL false_start_idle busy=%b after=%0d limit=%0d", busy, n, HALF + 3); end
    tick(DELAY);
    checks++; if (vcyc != 0 || fe_cnt != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL false_start_quiet valid=%0d fe=%0d busy=%b exp 0/0/0", vcyc, fe_cnt, busy);
    end
    for (int k = 0; k < 3; k++) begin
      got_q.delete();
      b = 8'($urandom);
      j = int'($urandom_range(0, 7));
      b[j] = 1'b1;
      send_frame(b, 1'b1, j);
      tick(5);
      checks++; if (got_q.size() != 1 || got_q[0] !== b) begin
        failures++; $display("FAIL glitch_bit%0d got_n=%0d exp=%h", j, got_q.size(), b);
      end
    end
  endtask

  task automatic test_frame_error;
    data_ready = 1'b1;
    got_q.delete();
    vcyc = 0;
    fe_cnt = 0;
    send_frame(8'h55, 1'b0, -1);
    tick(2 * DELAY);
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt); end
    checks++; if (vcyc != 0) begin failures++; $display("FAIL ferr_no_valid got=%0d exp=0", vcyc); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_break_busy got=%b exp=1", busy); end
    rx = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_release got=%b exp=0", busy); end
    tick(DELAY);
    send_byte(8'hA5);
    tick(5);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5 || fe_cnt != 1) begin
      failures++; $display("FAIL ferr_recover got_n=%0d fe=%0d exp byte a5 fe=1", got_q.size(), fe_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
    data_ready = 1'b0;
    x = 8'($urandom) | 8'h01;
    y = 8'($urandom);
    p = 8'($urandom);
    send_byte(x);
    send_byte(y);
    tick(3);
    checks++; if (data_out !== x || overrun !== 1'b1) begin
      failures++; $display("FAIL rmid_pre data=%h ovr=%b exp=%h/1", data_out, overrun, x);
    end
    rx = 1'b0;
    tick(DELAY);
    for (int i = 0; i < 4; i++) begin
      rx = p[i];
      tick(DELAY);
    end
    rx = p[4];
    tick(HALF);
    reset = 1'b0;
    tick(1);
    checks++; if (data_out !== 8'h00 || data_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL rmid_outputs data=%h v=%b ovr=%b busy=%b fe=%b exp all 0", data_out, data_valid, overrun, busy, frame_err);
    end
    reset = 1'b1;
    rx = 1'b1;
    got_q.delete();
    vcyc = 0;
    fe_cnt = 0;
    tick(2 * DELAY);
    checks++; if (vcyc != 0 || fe_cnt != 0) begin
      failures++; $display("FAIL rmid_abandon valid=%0d fe=%0d exp 0/0", vcyc, fe_cnt);
    end
    data_ready = 1'b1;
    send_byte(8'h3C);
    tick(5);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      failures++; $display("FAIL rmid_next got_n=%0d exp=3c", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_false_start();
    test_frame_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
